leaf_delta_sched: RTL and testbench
===================================

Name: leaf_delta_sched

Overview:
- Round-robin scheduler that shares one leaf_delta accumulate datapath between NUM_REQ requesters.
- Each grant is a fixed burst of BURST_LEN operand pairs:
  - clear the datapath accumulator;
  - stream the granted requester's operands into it;
  - capture the datapath result on the last beat;
  - return that result, tagged with the requester id, on a valid/ready response channel.
- Sits between the leaf-level operand sources and a single leaf_delta instance.

Parameters:
- WIDTH, 16, operand/result width; must match the datapath.
- NUM_REQ, 4, number of requesters (≥2).
- BURST_LEN, 8, operand pairs per grant (≥1).
- TIMEOUT, 64, stall-cycle limit (only used with LEAF_DELTA_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester operand ready; one-hot or zero.
- req_vec_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_vec_b  in  NUM_REQ*WIDTH  packed operand B; same packing.
- dp_vec_a  out  WIDTH  operand A to datapath.
- dp_vec_b  out  WIDTH  operand B to datapath.
- dp_clear_n  out  1  datapath accumulator clear, active-low, flop-driven; wired to datapath rst_n.
- dp_result  in  WIDTH  datapath result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the response.
- rsp_data  out  WIDTH  captured datapath result.
- rsp_abort  out  1  response is an aborted burst (tied 0 without the optional feature).

Behaviour:
- FSM states: IDLE, CLEAR, RUN, RESP.
- Reset (rst high at a clk edge), including mid-burst:
  - state=IDLE; rr pointer=0; beat counter=0;
  - req_ready=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_abort=0;
  - dp_clear_n=0, so the datapath is held clear; dp_vec_a=dp_vec_b=0.
  - Any in-flight burst is discarded with no response.
- IDLE:
  - Arbitrates over req_valid, searching from rr pointer upward with wrap-around; the first set bit wins.
  - No requester valid: stay in IDLE.
  - Otherwise latch grant and go to CLEAR next cycle.
  - req_ready=0 throughout IDLE.
- CLEAR:
  - Lasts exactly one cycle; dp_clear_n=0 for exactly this cycle (1 in all other non-reset cycles).
  - Operands driven 0; req_ready=0; next state RUN.
- RUN:
  - req_ready[grant]=1; all other ready bits 0.
  - A beat fires on req_valid[grant] & req_ready[grant]. On a firing beat, dp_vec_a/dp_vec_b = granted slice; otherwise both 0. A zero operand pair leaves the accumulator unchanged, so stalls are harmless.
  - On the beat where counter == BURST_LEN-1:
    - capture rsp_data <= dp_result in that same cycle;
    - rsp_id <= grant;
    - go to RESP; counter resets to 0.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data held stable until rsp_valid & rsp_ready. req_ready=0.
  - On handshake: rr pointer <= (grant+1) mod NUM_REQ; go to IDLE.
- Latency (requester valid in IDLE at cycle 0, no stalls):
  - CLEAR at cycle 1; first req_ready at cycle 2.
  - Last beat at cycle BURST_LEN+1; rsp_valid at cycle BURST_LEN+2.
- Fairness: a requester holding valid high is served within NUM_REQ grants.
- Requesters that drop valid in IDLE are not granted. A grant is never revoked without the optional feature.
- Simultaneous rsp_ready and new req_valid in RESP: the response completes first; arbitration happens in the following IDLE cycle (one idle bubble minimum between bursts).

Optional Feature:
- Macro: LEAF_DELTA_SCHED_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive RUN cycles without a firing beat and resets on each beat.
  - When it reaches TIMEOUT: go to RESP with rsp_abort=1, rsp_data=0, rsp_id=grant. The rr pointer advances normally after the response handshake.
- Undefined: no counter logic; rsp_abort tied 0; RUN waits indefinitely.

Test Plan:
- Single burst (WIDTH=16, BURST_LEN=2): requester 1 sends vec_a=0x0001, vec_b=0x0004 twice -> dp_clear_n low for 1 cycle; rsp_valid at cycle 4; rsp_id=1; rsp_data=0x0005.
- Round robin: all four requesters hold valid -> grant order 0,1,2,3,0. After the rsp for id 2 handshakes, the next grant is 3, not 0.
- Back-pressure: rsp_ready=0 for 10 cycles in RESP -> rsp_id/rsp_data stable; all req_ready=0; no new CLEAR until the handshake.
- Operand stalls: requester deasserts valid for 5 cycles mid-burst -> dp_vec_a/b=0 during the stall; rsp_data identical to the no-stall run (0x0005 case).
- Reset mid-RUN after 1 beat: rst high 1 cycle -> next cycle state IDLE, all outputs at reset values, no response emitted, rr pointer=0.
- (LEAF_DELTA_SCHED_TIMEOUT_EN, TIMEOUT=4) granted requester never asserts valid -> after 4 RUN cycles rsp_valid=1, rsp_abort=1, rsp_data=0.

Source files
------------

// File: rtl/leaf_delta_sched.sv
// leaf_delta_sched: round-robin scheduler sharing one leaf_delta accumulate
// datapath between NUM_REQ requesters. Each grant clears the datapath, streams
// BURST_LEN operand pairs from the granted requester, captures the result on
// the last beat and returns it on a valid/ready response channel.
// Optional feature: define LEAF_DELTA_SCHED_TIMEOUT_EN to abort a burst after
// TIMEOUT consecutive stalled RUN cycles (response flagged with rsp_abort).
module leaf_delta_sched #(
  parameter int WIDTH     = 16,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_vec_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_vec_b,
  output logic [WIDTH-1:0]           dp_vec_a,
  output logic [WIDTH-1:0]           dp_vec_b,
  output logic                       dp_clear_n,
  input  logic [WIDTH-1:0]           dp_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_abort
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               dp_clear_n_q, dp_clear_n_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic               arb_any;
  logic [ID_W-1:0]    arb_win;
  int                 arb_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               fire;

`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               rsp_abort_q, rsp_abort_d;
`endif

  // Round-robin arbiter: first valid requester at or above rr_q, wrapping.
  always_comb begin
    arb_any = 1'b0;
    arb_win = '0;
    arb_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      arb_idx = int'(rr_q) + k;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (req_valid[ID_W'(arb_idx)]) begin
        arb_any = 1'b1;
        arb_win = ID_W'(arb_idx);
      end
    end
  end

  // Granted requester's operand slice and one-hot ready pattern.
  always_comb begin
    sel_a        = '0;
    sel_b        = '0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_a           = req_vec_a[i*WIDTH +: WIDTH];
        sel_b           = req_vec_b[i*WIDTH +: WIDTH];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // A beat fires only while the granted ready bit is up; stalls feed zeros.
  assign fire     = |(req_valid & req_ready_q);
  assign dp_vec_a = fire ? sel_a : '0;
  assign dp_vec_b = fire ? sel_b : '0;

  // Next-state logic for the burst sequencer.
  always_comb begin
    // NOTE: every _d signal takes a default first so no branch leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    dp_clear_n_d = 1'b1;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
    stall_d      = stall_q;
    rsp_abort_d  = rsp_abort_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        req_ready_d = '0;
        if (arb_any) begin
          grant_d      = arb_win;
          dp_clear_n_d = 1'b0;
          state_d      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d       = '0;
        req_ready_d = grant_onehot;
        state_d     = S_RUN;
`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
        stall_d     = '0;
`endif
      end
      S_RUN: begin
        if (fire) begin
`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
          stall_d = '0;
`endif
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            cnt_d       = '0;
            req_ready_d = '0;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_q;
            rsp_data_d  = dp_result;
            state_d     = S_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
        else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
          stall_d     = '0;
          cnt_d       = '0;
          req_ready_d = '0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = grant_q;
          rsp_data_d  = '0;
          rsp_abort_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_d        = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d     = S_IDLE;
`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
          rsp_abort_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      dp_clear_n_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
      stall_q      <= '0;
      rsp_abort_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      dp_clear_n_q <= dp_clear_n_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
      stall_q      <= stall_d;
      rsp_abort_q  <= rsp_abort_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign dp_clear_n = dp_clear_n_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
  assign rsp_abort  = rsp_abort_q;
`else
  assign rsp_abort  = 1'b0;
`endif

endmodule

// File: tb/tb_leaf_delta_sched.sv
// Testbench for leaf_delta_sched: directed scenarios plus a randomized phase,
// all checked against a burst-level reference model and a behavioural
// accumulate datapath living in this file.
module tb_leaf_delta_sched;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int BL = 2;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_vec_a, req_vec_b;
  logic [W-1:0]     dp_vec_a, dp_vec_b, dp_result;
  logic             dp_clear_n;
  logic             rsp_valid, rsp_ready, rsp_abort;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  leaf_delta_sched #(.WIDTH(W), .NUM_REQ(N), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vec_a(req_vec_a), .req_vec_b(req_vec_b),
    .dp_vec_a(dp_vec_a), .dp_vec_b(dp_vec_b), .dp_clear_n(dp_clear_n),
    .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_abort(rsp_abort)
  );

  // Behavioural leaf_delta datapath: registered accumulator of a+b, async clear.
  logic [W-1:0] acc;
  always @(posedge clk or negedge dp_clear_n)
    if (!dp_clear_n) acc <= '0;
    else             acc <= acc + dp_vec_a + dp_vec_b;
  assign dp_result = acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (burst timeline) ----------------
  typedef enum {P_IDLE, P_CLEAR, P_RUN, P_RESP} phase_e;
  phase_e       m_ph = P_IDLE;
  int           m_rr = 0, m_grant = 0, m_beats = 0, m_stall = 0;
  logic [W-1:0] m_sum = '0, m_data = '0;
  logic         m_abort = 1'b0, m_after_rst = 1'b1;

  always @(negedge clk) begin : model
    logic [N-1:0] e_ready;
    logic         e_fire, found;
    logic [W-1:0] g_a, g_b;
    e_ready = '0;
    if (m_ph == P_RUN) e_ready[m_grant] = 1'b1;
    e_fire = |(req_valid & e_ready);
    g_a = req_vec_a[m_grant*W +: W];
    g_b = req_vec_b[m_grant*W +: W];

    check("req_ready", req_ready, e_ready);
    check("dp_clear_n", dp_clear_n, (m_after_rst || m_ph == P_CLEAR) ? 1'b0 : 1'b1);
    check("rsp_valid", rsp_valid, m_ph == P_RESP);
    check("dp_vec_a", dp_vec_a, e_fire ? g_a : '0);
    check("dp_vec_b", dp_vec_b, e_fire ? g_b : '0);
    check("rsp_abort", rsp_abort, (m_ph == P_RESP) ? m_abort : 1'b0);
    if (m_ph == P_RESP) begin
      check("rsp_id", rsp_id, m_grant);
      check("rsp_data", rsp_data, m_data);
    end else if (m_after_rst) begin
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
    end

    if (rst) begin
      m_ph = P_IDLE; m_rr = 0; m_after_rst = 1'b1; m_abort = 1'b0;
    end else begin
      m_after_rst = 1'b0;
      case (m_ph)
        P_IDLE: if (|req_valid) begin
          found = 1'b0;
          for (int k = 0; k < N; k++)
            if (!found && req_valid[(m_rr + k) % N]) begin
              m_grant = (m_rr + k) % N;
              found   = 1'b1;
            end
          m_ph = P_CLEAR;
        end
        P_CLEAR: begin
          m_ph = P_RUN; m_beats = 0; m_sum = '0; m_stall = 0;
        end
        P_RUN: if (e_fire) begin
          m_stall = 0;
          if (m_beats == BL - 1) begin
            m_data = m_sum; m_abort = 1'b0; m_ph = P_RESP;
          end else begin
            m_sum = m_sum + g_a + g_b;
            m_beats++;
          end
        end else begin
`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
          m_stall++;
          if (m_stall == TO) begin
            m_data = '0; m_abort = 1'b1; m_ph = P_RESP;
          end
`endif
        end
        P_RESP: if (rsp_ready) begin
          m_rr = (m_grant + 1) % N;
          m_ph = P_IDLE;
        end
        default: m_ph = P_IDLE;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_vec_a[i*W +: W] = a;
    req_vec_b[i*W +: W] = b;
  endtask

  // Returns at the negedge where rsp_valid is seen; n = cycles waited.
  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!rsp_valid) check("rsp_wait_timeout", rsp_valid, 1);
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready[i]) check("ready_wait_timeout", req_ready[i], 1);
  endtask

  task automatic finish_rsp();
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    int ids[5];
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    logic [1:0]   id0;
    logic [W-1:0] d0;

    rst = 1'b1; req_valid = '0; req_vec_a = '0; req_vec_b = '0; rsp_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Single burst from requester 1: beats (1,4),(1,4) -> result of first beat.
    set_ops(1, 16'h0001, 16'h0004);
    req_valid = 4'b0010;
    wait_rsp(n);
    check("single_latency", n, BL + 2);
    check("single_id", rsp_id, 1);
    check("single_data", rsp_data, 16'h0005);
    finish_rsp();

    // Round robin from rr=0 with everybody valid.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
    rsp_ready = 1'b1;
    req_valid = '1;
    n = 0; seen = 0;
    while (seen < 5 && n < 200) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ids[seen] = rsp_id;
        seen++;
      end
      n++;
    end
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    check("rr_count", seen, 5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), ids[i], exp_ids[i]);

    // Back-pressure: response held for 10 cycles while others wait.
    req_valid = 4'b0100;
    wait_rsp(n);
    id0 = rsp_id; d0 = rsp_data;
    check("bp_id", id0, 2);
    step();
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_id_stable", rsp_id, id0);
      check("bp_data_stable", rsp_data, d0);
      check("bp_no_ready", req_ready, 0);
      check("bp_no_clear", dp_clear_n, 1);
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Operand stall of 5 cycles mid-burst; result unaffected.
    set_ops(1, 16'h0001, 16'h0004);
    req_valid = 4'b0010;
    wait_ready(1);
    step();
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_vec_a", dp_vec_a, 0);
      check("stall_vec_b", dp_vec_b, 0);
      check("stall_ready", req_ready, 4'b0010);
      @(posedge clk); #1;
    end
    req_valid = 4'b0010;
    wait_rsp(n);
    check("stall_id", rsp_id, 1);
    check("stall_data", rsp_data, 16'h0005);
    finish_rsp();

    // Reset mid-RUN after one beat: burst dropped, rr back to 0.
    set_ops(2, W'($urandom), W'($urandom));
    req_valid = 4'b0100;
    wait_ready(2);
    step();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ready", req_ready, 0);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_clear_n", dp_clear_n, 0);
    check("mrst_vec_a", dp_vec_a, 0);
    check("mrst_rsp_id", rsp_id, 0);
    check("mrst_rsp_data", rsp_data, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mrst_no_rsp", seen, 0);
    @(posedge clk); #1;
    req_valid = 4'b1101;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("mrst_rr_zero", req_ready, 4'b0001);
    wait_rsp(n);
    finish_rsp();

    // Granted requester never supplies operands.
    req_valid = 4'b0001;
    n = 0;
    @(negedge clk);
    while (dp_clear_n && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("to_clear_seen", dp_clear_n, 0);
    step();
    req_valid = '0;
`ifdef LEAF_DELTA_SCHED_TIMEOUT_EN
    wait_rsp(n);
    check("to_latency", n, TO);
    check("to_abort", rsp_abort, 1);
    check("to_data", rsp_data, 0);
    check("to_id", rsp_id, 0);
    finish_rsp();
`else
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_to_waits", seen, 0);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    wait_rsp(n);
    check("no_to_abort", rsp_abort, 0);
    finish_rsp();
`endif

    // Randomized traffic, back-pressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) req_valid[i] = ~req_valid[i];
        set_ops(i, W'($urandom), W'($urandom));
      end
      rsp_ready = ($urandom_range(2) != 0);
      rst = ($urandom_range(399) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
